// File: rtl/onehot_hold_arb_pkg.sv
// onehot_hold_arb_pkg: shared defaults and helpers for the one-hot hold arbiter.
package onehot_hold_arb_pkg;

    localparam int DEF_MIN_HOLD = 3;
    localparam int DEF_MAX_HOLD = 8;
    localparam int MAX_N        = 32;

    function automatic logic [MAX_N-1:0] idx2onehot(input int idx);
        return MAX_N'(1) << idx;
    endfunction

    function automatic int cnt_width(input int max_hold);
        return ($clog2(max_hold) < 1) ? 1 : $clog2(max_hold);
    endfunction

endpackage

// File: rtl/onehot_rr_pick.sv
// onehot_rr_pick: rotating-priority search, first set bit above start_idx with wrap-around.
module onehot_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  others,
    input  logic [IW-1:0] start_idx,
    output logic [IW-1:0] pick_idx,
    output logic          any_req
);

    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;
    logic          has_hi;

    // Lowest requester above start_idx wins, otherwise the lowest one at or below it.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        has_hi = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (others[k]) begin
                if (k > int'(start_idx)) begin
                    hi_idx = IW'(k);
                    has_hi = 1'b1;
                end else begin
                    lo_idx = IW'(k);
                end
            end
        end
        pick_idx = has_hi ? hi_idx : lo_idx;
        any_req  = |others;
    end

endmodule

// File: rtl/onehot_hold_arb.sv
// onehot_hold_arb: round-robin arbiter with an always one-hot grant held MIN_HOLD..MAX_HOLD cycles.
// Define ONEHOT_HOLD_ARB_ASSERT_EN to include the built-in concurrent assertions.
module onehot_hold_arb
    import onehot_hold_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MIN_HOLD = DEF_MIN_HOLD,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 lock,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 switched,
    output logic                 gnt_valid
);

    localparam int IW = $clog2(N);
    localparam int CW = cnt_width(MAX_HOLD);

    logic [CW-1:0] cnt;
    logic [N-1:0]  others;
    logic          owner_req;
    logic          eligible;
    logic          at_max;
    logic          do_switch;
    logic [IW-1:0] pick_idx;
    logic          any_req;

    onehot_rr_pick #(.N(N), .IW(IW)) u_pick (
        .others    (others),
        .start_idx (grant_idx),
        .pick_idx  (pick_idx),
        .any_req   (any_req)
    );

    assign gnt_valid = |(req & grant);

    // Switch only once the hold window has elapsed and someone else is waiting;
    // the owner leaves when it stops requesting or, unlocked, when its time is up.
    always_comb begin
        others    = req & ~grant;
        owner_req = |(req & grant);
        eligible  = cnt >= CW'(MIN_HOLD - 1);
        at_max    = cnt == CW'(MAX_HOLD - 1);
        do_switch = eligible && any_req && (!owner_req || (at_max && !lock));
    end

    // Grant, index, hold counter and switch pulse; reset parks the grant on bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= N'(1);
            grant_idx <= '0;
            cnt       <= '0;
            switched  <= 1'b0;
        end else begin
            switched <= do_switch;
            if (do_switch) begin
                grant     <= N'(idx2onehot(int'(pick_idx)));
                grant_idx <= pick_idx;
                cnt       <= '0;
            end else if (!at_max) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef ONEHOT_HOLD_ARB_ASSERT_EN
    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("onehot_hold_arb: N must be in 2..%0d", MAX_N);
    end
    if (MIN_HOLD < 1) begin : g_bad_min
        $error("onehot_hold_arb: MIN_HOLD must be >= 1");
    end
    if (MAX_HOLD < MIN_HOLD) begin : g_bad_max
        $error("onehot_hold_arb: MAX_HOLD must be >= MIN_HOLD");
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(grant));

    if (MIN_HOLD > 1) begin : g_hold
        a_hold: assert property (@(posedge clk) disable iff (!rst_n)
            !$stable(grant) |=> $stable(grant)[*MIN_HOLD-1]);
    end

    a_switched: assert property (@(posedge clk) disable iff (!rst_n)
        switched == !$stable(grant));

    a_idx: assert property (@(posedge clk) disable iff (!rst_n)
        grant == (N'(1) << grant_idx));
`endif

endmodule

// File: tb/tb_onehot_hold_arb.sv
// tb_onehot_hold_arb: randomized scoreboard bench against a cycle-count reference model.
module tb_onehot_hold_arb;

    localparam int N        = 4;
    localparam int MIN_HOLD = 3;
    localparam int MAX_HOLD = 8;

    typedef struct {
        logic [N-1:0] g;
        int           idx;
        logic         sw;
        logic         gv;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lock = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic [1:0]   grant_idx;
    logic         switched;
    logic         gnt_valid;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_own  = 0;
    int   m_held = 1;

    onehot_hold_arb #(.N(N), .MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .grant     (grant),
        .grant_idx (grant_idx),
        .switched  (switched),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_held counts cycles the current grant has been visible (1 on the cycle it appears).
    task automatic predict();
        int   nxt;
        bit   oreq;
        exp_t e;
        nxt  = -1;
        oreq = req[m_own];
        for (int k = 1; k < N; k++) begin
            if (nxt < 0 && req[(m_own + k) % N]) nxt = (m_own + k) % N;
        end
        if (m_held >= MIN_HOLD && nxt >= 0 && (!oreq || (m_held >= MAX_HOLD && !lock))) begin
            m_own  = nxt;
            m_held = 1;
            e.sw   = 1'b1;
        end else begin
            m_held++;
            e.sw = 1'b0;
        end
        e.g   = N'(1) << m_own;
        e.idx = m_own;
        e.gv  = req[m_own];
        sb.push_back(e);
    endtask

    task automatic apply(input logic [N-1:0] r, input logic l);
        req  = r;
        lock = l;
        predict();
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic l);
        @(posedge clk);
        #2;
        apply(r, l);
    endtask

    // Asynchronous pulse between edges; outputs must drop before any clock edge.
    task automatic do_reset(input logic [N-1:0] r, input logic l);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", grant, 1);
        check("async_rst_idx", grant_idx, 0);
        check("async_rst_switched", switched, 0);
        sb.delete();
        #1;
        rst_n  = 1'b1;
        m_own  = 0;
        m_held = 1;
        apply(r, l);
    endtask

    // Monitor: each edge's registered outputs are compared to the oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("grant", grant, e.g);
                check("grant_idx", grant_idx, e.idx);
                check("switched", switched, e.sw);
                check("gnt_valid", gnt_valid, e.gv);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_grant", grant, 1);
        check("reset_idx", grant_idx, 0);
        check("reset_switched", switched, 0);
        // Idle: grant parks on bit 0.
        do_reset('0, 1'b0);
        repeat (20) cyc('0, 1'b0);
        // Single requester from the first edge after release.
        do_reset(4'b0010, 1'b0);
        repeat (6) cyc(4'b0010, 1'b0);
        // All requesting, unlocked: full MAX_HOLD rotation with wrap.
        do_reset(4'b1111, 1'b0);
        repeat (40) cyc(4'b1111, 1'b0);
        // New owner drops request right after winning; still held MIN_HOLD.
        do_reset(4'b0100, 1'b0);
        repeat (2) cyc(4'b0100, 1'b0);
        repeat (6) cyc(4'b1000, 1'b0);
        // Lock keeps the owner past MAX_HOLD until released.
        do_reset(4'b1111, 1'b1);
        repeat (30) cyc(4'b1111, 1'b1);
        repeat (4) cyc(4'b1111, 1'b0);
        // Reset mid-hold, then resume.
        do_reset(4'b0100, 1'b0);
        repeat (3) cyc(4'b0100, 1'b0);
        do_reset(4'b0110, 1'b0);
        repeat (8) cyc(4'b0110, 1'b0);
        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            logic [N-1:0] r;
            logic         l;
            r = N'($urandom);
            l = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) do_reset(r, l);
            else cyc(r, l);
        end
        @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onehot_hold_arb.md
Name: onehot_hold_arb

Overview:
- Round-robin arbiter that shares one resource among N requesters through a one-hot select bus.
- The grant bus is always exactly one-hot, including in reset.
- Every grant value is held for at least MIN_HOLD cycles, so the selected resource sees a stable one-hot select.
- Sits in front of any datapath whose select input must be one-hot and glitch-free.

Parameters:
- N, 4, number of requesters (N >= 2).
- MIN_HOLD, 3, minimum cycles a grant value stays visible (>= 1).
- MAX_HOLD, 8, cycles after which an active owner is pre-empted if others wait (>= MIN_HOLD).

Ports:
- clk  input  1  single clock; all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector, level-sensitive.
- lock  input  1  owner holds the grant past MAX_HOLD while its req is high.
- grant  output  N  one-hot select, registered.
- grant_idx  output  $clog2(N)  binary index of grant, registered.
- switched  output  1  registered pulse, high in the first cycle a new grant is visible.
- gnt_valid  output  1  combinational, equals |(req & grant).

Behaviour:
- Reset (async assert, sync-free release): grant=1 (bit 0 parked), grant_idx=0, cnt=0, switched=0.
- Reset mid-operation drops to these values immediately, without a clock edge.
- cnt: width max(1,$clog2(MAX_HOLD)).
  - Cleared to 0 on the edge that loads a new grant.
  - Otherwise increments each edge, saturating at MAX_HOLD-1.
- eligible = (cnt >= MIN_HOLD-1).
- others = req & ~grant.
- owner_req = |(req & grant).
- Switch occurs on an edge only when all of the following hold:
  - eligible;
  - others != 0;
  - at least one of: !owner_req; (cnt == MAX_HOLD-1 && !lock); or (cnt == MAX_HOLD-1 && lock && !owner_req).
- lock has no effect when owner_req=0.
- New owner: the first requester in others, searching upward from grant_idx+1 and wrapping modulo N. The current owner is never re-selected by a switch.
- No switch: grant and grant_idx hold. With no requests, grant stays on the current owner (no return to bit 0).
- Resulting timing, stated as guarantees:
  - A grant changed at edge t stays stable for edges t+1 .. t+MIN_HOLD-1.
  - Earliest next change is edge t+MIN_HOLD.
  - An owner with continuous req, lock=0, and others waiting is held exactly MAX_HOLD cycles.
- After reset, bit 0 is subject to MIN_HOLD like any grant. The first possible switch is the MIN_HOLD-th edge after rst_n release.
- switched=1 exactly on the edge grant changes, 0 otherwise. It is never asserted two cycles in a row when MIN_HOLD > 1.
- Simultaneous owner req drop and others rising on an eligible edge: switch on that edge.
- req changes during the hold window are ignored until eligible.

Optional Feature:
- Macro ONEHOT_HOLD_ARB_ASSERT_EN.
- When defined, the module contains concurrent assertions, clocked on posedge clk and disabled iff !rst_n:
  - $onehot(grant) on every cycle;
  - !$stable(grant) |=> $stable(grant)[*MIN_HOLD-1];
  - switched == !$stable(grant);
  - grant == (1 << grant_idx);
  - N, MIN_HOLD and MAX_HOLD legality checks at elaboration.
- When not defined: no assertion code, and identical RTL behaviour.

Decomposition:
- Package onehot_hold_arb_pkg:
  - function idx2onehot;
  - function cnt_width(MAX_HOLD);
  - localparam-style defaults DEF_MIN_HOLD=3, DEF_MAX_HOLD=8.
- Sub-module onehot_rr_pick: combinational.
  - Inputs: others[N], start_idx.
  - Outputs: pick_idx and any_req, implementing the rotating-priority search with wrap-around.

Test Plan (N=4, MIN_HOLD=3, MAX_HOLD=8):
1. Reset, then req=0000 for 20 cycles -> grant=0001, grant_idx=0, switched=0 throughout.
2. From the first edge after reset release, req=0010 -> grant=0010 on the 3rd edge, switched high for exactly that cycle, gnt_valid=1.
3. req=1111 held, lock=0 -> grant cycles 0001→0010→0100→1000→0001 (wrap), each held exactly 8 cycles.
4. Owner 0100 drops req on the cycle after gaining grant, req=1000 -> grant stays 0100 for 3 cycles total, then becomes 1000.
5. Owner 0001, lock=1, req=1111 for 30 cycles -> no switch. lock falls -> grant=0010 on the next edge.
6. grant=0100 with cnt=1, rst_n pulsed low between edges -> grant=0001 and switched=0 immediately. Normal arbitration resumes with a 3-cycle hold.
